up_bus_arbiter: RTL and testbench

//  Shares one uP register bus slave (up_uart register port) between two uP bus masters
//  (m0: up_axi bridge, m1: second host such as a debug/loader port).

---
 rtl/up_arb_pkg.sv | 29 ++
 rtl/up_arb_rr_pick.sv | 29 ++
 rtl/up_bus_arbiter.sv | 152 +++++++++++++++
 tb/tb_up_bus_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/up_arb_pkg.sv
// Shared types for the uP bus arbiter: FSM states, transaction source encoding and
// the default read-timeout error word.
package up_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  // bit 1 = master index, bit 0 = read
  typedef enum logic [1:0] {
    M0_W = 2'b00,
    M0_R = 2'b01,
    M1_W = 2'b10,
    M1_R = 2'b11
  } src_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  function automatic logic src_master(input src_t s);
    return s[1];
  endfunction

  function automatic logic src_is_read(input src_t s);
    return s[0];
  endfunction

endpackage

// File: rtl/up_arb_rr_pick.sv
// Combinational two-master picker: the pointer master wins if it has anything pending,
// otherwise the other master; within the winning master a write beats a read.
module up_arb_rr_pick
  import up_arb_pkg::*;
(
  input  logic i_m0_wreq,
  input  logic i_m0_rreq,
  input  logic i_m1_wreq,
  input  logic i_m1_rreq,
  input  logic i_ptr,
  output logic o_valid,
  output src_t o_src
);

  logic w_has0;
  logic w_has1;
  logic w_master;
  logic w_write;

  always_comb begin
    w_has0   = i_m0_wreq | i_m0_rreq;
    w_has1   = i_m1_wreq | i_m1_rreq;
    w_master = i_ptr ? w_has1 : ~w_has0;
    w_write  = w_master ? i_m1_wreq : i_m0_wreq;
    o_valid  = w_has0 | w_has1;
    o_src    = src_t'({w_master, ~w_write});
  end

endmodule

// File: rtl/up_bus_arbiter.sv
// Round-robin arbiter sharing one uP register slave between two uP bus masters,
// one transaction outstanding, with a per-transaction slave-ack timeout.
module up_bus_arbiter
  import up_arb_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     m0_wreq,
  input  logic [ADDRESS_WIDTH-3:0] m0_waddr,
  input  logic [31:0]              m0_wdata,
  output logic                     m0_wack,
  input  logic                     m0_rreq,
  input  logic [ADDRESS_WIDTH-3:0] m0_raddr,
  output logic [31:0]              m0_rdata,
  output logic                     m0_rack,
  input  logic                     m1_wreq,
  input  logic [ADDRESS_WIDTH-3:0] m1_waddr,
  input  logic [31:0]              m1_wdata,
  output logic                     m1_wack,
  input  logic                     m1_rreq,
  input  logic [ADDRESS_WIDTH-3:0] m1_raddr,
  output logic [31:0]              m1_rdata,
  output logic                     m1_rack,
  output logic                     s_wreq,
  output logic [ADDRESS_WIDTH-3:0] s_waddr,
  output logic [31:0]              s_wdata,
  input  logic                     s_wack,
  output logic                     s_rreq,
  output logic [ADDRESS_WIDTH-3:0] s_raddr,
  input  logic [31:0]              s_rdata,
  input  logic                     s_rack,
  output logic                     grant,
  output logic                     timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t                   r_state;
  state_t                   w_state_nxt;
  src_t                     r_src;
  logic                     r_ptr;
  logic                     r_grant;
  logic                     r_timeout;
  logic [ADDRESS_WIDTH-3:0] r_addr;
  logic [31:0]              r_wdata;
  logic [31:0]              r_rdata;
  logic [CW-1:0]            r_cnt;

  logic                     w_valid;
  src_t                     w_pick;
  logic                     w_slave_ack;
  logic                     w_cnt_hit;
  logic                     w_busy;
  logic                     w_ack;

  up_arb_rr_pick u_pick (
    .i_m0_wreq (m0_wreq),
    .i_m0_rreq (m0_rreq),
    .i_m1_wreq (m1_wreq),
    .i_m1_rreq (m1_rreq),
    .i_ptr     (r_ptr),
    .o_valid   (w_valid),
    .o_src     (w_pick)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Only the ack matching the granted channel counts; a hit and an ack together
  // resolve as a normal completion.
  always_comb begin
    w_state_nxt = r_state;
    w_slave_ack = src_is_read(r_src) ? s_rack : s_wack;
    w_cnt_hit   = (r_cnt == CNT_LAST);
    unique case (r_state)
      IDLE:    if (w_valid) w_state_nxt = BUSY;
      BUSY:    if (w_slave_ack || w_cnt_hit) w_state_nxt = ACK;
      ACK:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_src     <= M0_W;
      r_ptr     <= 1'b0;
      r_grant   <= 1'b0;
      r_timeout <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_cnt     <= '0;
    end else begin
      r_timeout <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_src   <= w_pick;
            r_grant <= src_master(w_pick);
            r_wdata <= src_master(w_pick) ? m1_wdata : m0_wdata;
            r_cnt   <= '0;
            unique case (w_pick)
              M0_W: r_addr <= m0_waddr;
              M0_R: r_addr <= m0_raddr;
              M1_W: r_addr <= m1_waddr;
              M1_R: r_addr <= m1_raddr;
              default: r_addr <= '0;
            endcase
          end
        end
        BUSY: begin
          if (w_slave_ack) begin
            r_rdata <= s_rdata;
          end else if (w_cnt_hit) begin
            r_rdata   <= ERR_DATA;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
          if (w_slave_ack || w_cnt_hit) r_ptr <= ~src_master(r_src);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_busy   = (r_state == BUSY);
    w_ack    = (r_state == ACK);
    s_wreq   = w_busy & ~src_is_read(r_src);
    s_rreq   = w_busy &  src_is_read(r_src);
    s_waddr  = r_addr;
    s_raddr  = r_addr;
    s_wdata  = r_wdata;
    m0_wack  = w_ack & (r_src == M0_W);
    m0_rack  = w_ack & (r_src == M0_R);
    m1_wack  = w_ack & (r_src == M1_W);
    m1_rack  = w_ack & (r_src == M1_R);
    m0_rdata = m0_rack ? r_rdata : '0;
    m1_rdata = m1_rack ? r_rdata : '0;
    grant    = r_grant;
    timeout  = r_timeout;
  end

endmodule

// File: tb/tb_up_bus_arbiter.sv
// Self-checking bench for up_bus_arbiter: transaction-level reference model compared
// every cycle, directed scenarios with literal expectations, then a randomized run.
module tb_up_bus_arbiter;

  localparam int AW = 32;
  localparam int WA = AW - 2;
  localparam int TO = 8;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          wreq[2];
  logic          rreq[2];
  logic [WA-1:0] waddr[2];
  logic [WA-1:0] raddr[2];
  logic [31:0]   wdata[2];
  logic          wack[2];
  logic          rack[2];
  logic [31:0]   rdata[2];
  logic          s_wreq, s_rreq, s_wack, s_rack;
  logic [WA-1:0] s_waddr, s_raddr;
  logic [31:0]   s_wdata, s_rdata;
  logic          grant, timeout;

  up_bus_arbiter #(
    .ADDRESS_WIDTH  (AW),
    .TIMEOUT_CYCLES (TO),
    .ERR_DATA       (ERR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m0_wreq  (wreq[0]),
    .m0_waddr (waddr[0]),
    .m0_wdata (wdata[0]),
    .m0_wack  (wack[0]),
    .m0_rreq  (rreq[0]),
    .m0_raddr (raddr[0]),
    .m0_rdata (rdata[0]),
    .m0_rack  (rack[0]),
    .m1_wreq  (wreq[1]),
    .m1_waddr (waddr[1]),
    .m1_wdata (wdata[1]),
    .m1_wack  (wack[1]),
    .m1_rreq  (rreq[1]),
    .m1_raddr (raddr[1]),
    .m1_rdata (rdata[1]),
    .m1_rack  (rack[1]),
    .s_wreq   (s_wreq),
    .s_waddr  (s_waddr),
    .s_wdata  (s_wdata),
    .s_wack   (s_wack),
    .s_rreq   (s_rreq),
    .s_raddr  (s_raddr),
    .s_rdata  (s_rdata),
    .s_rack   (s_rack),
    .grant    (grant),
    .timeout  (timeout)
  );

  // Reference model: a transaction sampled at an edge owns the slave for n cycles,
  // is acked in the next cycle, and the arbiter is free again one cycle later.
  int            age = 0, n = 1, win = 0, ptr = 0, gnt = 0, cur_lat = 1;
  bit            wr = 1'b0, timed = 1'b0;
  logic [WA-1:0] m_addr = '0;
  logic [31:0]   m_wdata = '0, m_rdata = '0;
  int            lat_q[$];
  logic [31:0]   rd_q[$];

  int  s_age = 0;
  bit  spur_en = 1'b0, late_ack = 1'b0, rand_mode = 1'b0;
  int  w_left[2];
  bit  r_auto[2];

  int            cyc = 0, sreq_cnt = 0, first_sreq_cyc = 0, to_cnt = 0, c0 = 0;
  logic [WA-1:0] first_addr = '0;
  logic [31:0]   first_wdata = '0;
  int            ack_q[$], ack_cyc[$], grant_q[$];
  logic [31:0]   rd_seen[2];

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int rand_lat();
    case ($urandom_range(0, 8))
      0, 1:    return 1;
      2:       return 2;
      3:       return 3;
      4:       return 4;
      5:       return TO - 1;
      6:       return TO;
      7:       return TO + 1;
      default: return 20;
    endcase
  endfunction

  task automatic model_step();
    bit h0, h1;
    if (rst) begin
      age = 0; ptr = 0; gnt = 0;
      return;
    end
    if (age == 0) begin
      h0 = wreq[0] | rreq[0];
      h1 = wreq[1] | rreq[1];
      if (h0 | h1) begin
        win     = (ptr == 1) ? (h1 ? 1 : 0) : (h0 ? 0 : 1);
        wr      = wreq[win];
        m_addr  = wr ? waddr[win] : raddr[win];
        m_wdata = wdata[win];
        cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : rand_lat();
        timed   = (cur_lat > TO);
        n       = timed ? TO : cur_lat;
        gnt     = win;
        age     = 1;
      end
    end else begin
      if (age == n) m_rdata = timed ? ERR : s_rdata;
      age++;
      if (age == n + 1) ptr = 1 - win;
      else if (age == n + 2) age = 0;
    end
  endtask

  task automatic check_outputs();
    bit in_req, in_ack;
    in_req = (age >= 1) && (age <= n);
    in_ack = (age == n + 1);
    chk("s_wreq", s_wreq, in_req && wr);
    chk("s_rreq", s_rreq, in_req && !wr);
    if (in_req && wr) begin
      chk("s_waddr", s_waddr, m_addr);
      chk("s_wdata", s_wdata, m_wdata);
    end
    if (in_req && !wr) chk("s_raddr", s_raddr, m_addr);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("m%0d_wack", i), wack[i], in_ack && (win == i) && wr);
      chk($sformatf("m%0d_rack", i), rack[i], in_ack && (win == i) && !wr);
      chk($sformatf("m%0d_rdata", i), rdata[i],
          (in_ack && (win == i) && !wr) ? m_rdata : 32'h0);
    end
    chk("grant", grant, 32'(gnt));
    chk("timeout", timeout, in_ack && timed);
  endtask

  task automatic monitor();
    if (s_wreq | s_rreq) begin
      if (sreq_cnt == 0) begin
        first_sreq_cyc = cyc;
        first_addr     = s_wreq ? s_waddr : s_raddr;
        first_wdata    = s_wdata;
      end
      sreq_cnt++;
    end
    for (int i = 0; i < 2; i++) begin
      if (wack[i]) begin ack_q.push_back(2 * i);     ack_cyc.push_back(cyc); grant_q.push_back(int'(grant)); end
      if (rack[i]) begin ack_q.push_back(2 * i + 1); ack_cyc.push_back(cyc); grant_q.push_back(int'(grant)); rd_seen[i] = rdata[i]; end
    end
    if (timeout) to_cnt++;
  endtask

  task automatic drive_slave();
    if (s_wreq | s_rreq) begin
      s_age++;
      s_wack  = s_wreq && (s_age == cur_lat);
      s_rack  = s_rreq && (s_age == cur_lat);
      s_rdata = $urandom;
      if (s_rack && rd_q.size() > 0) s_rdata = rd_q.pop_front();
    end else begin
      s_age    = 0;
      s_wack   = spur_en && ($urandom_range(0, 7) == 0);
      s_rack   = late_ack || (spur_en && ($urandom_range(0, 7) == 0));
      late_ack = 1'b0;
      s_rdata  = $urandom;
    end
  endtask

  task automatic drive_masters();
    bit dw, dr;
    for (int i = 0; i < 2; i++) begin
      dw = 1'b0; dr = 1'b0;
      if (wack[i]) begin wreq[i] = 1'b0; dw = 1'b1; end
      if (rack[i]) begin rreq[i] = 1'b0; dr = 1'b1; end
      if (!wreq[i] && !dw && (w_left[i] > 0 || (rand_mode && $urandom_range(0, 3) == 0))) begin
        wreq[i]  = 1'b1;
        waddr[i] = WA'($urandom);
        wdata[i] = $urandom;
        if (w_left[i] > 0) w_left[i]--;
      end
      if (!rreq[i] && !dr && (r_auto[i] || (rand_mode && $urandom_range(0, 3) == 0))) begin
        rreq[i]  = 1'b1;
        raddr[i] = WA'($urandom);
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
    check_outputs();
    drive_slave();
    drive_masters();
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < 2; i++) begin
      wreq[i] = 1'b0; rreq[i] = 1'b0; w_left[i] = 0; r_auto[i] = 1'b0;
    end
  endtask

  task automatic clear_stats();
    sreq_cnt = 0; to_cnt = 0;
    ack_q.delete(); ack_cyc.delete(); grant_q.delete();
    rd_seen[0] = '0; rd_seen[1] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_reqs();
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic run_until(input int nack, input int budget, input string nm);
    int k;
    k = 0;
    while (ack_q.size() < nack && k < budget) begin
      cycle();
      k++;
    end
    checks++;
    if (ack_q.size() < nack) begin
      errors++;
      $display("FAIL %s_wait: got %0d acks, required %0d within %0d cycles", nm, ack_q.size(), nack, budget);
    end
  endtask

  function automatic int q_at(input int idx);
    return (idx < ack_q.size()) ? ack_q[idx] : -1;
  endfunction

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wreq[i] = 1'b0; rreq[i] = 1'b0; waddr[i] = '0; raddr[i] = '0; wdata[i] = '0;
      w_left[i] = 0; r_auto[i] = 1'b0; rd_seen[i] = '0;
    end
    s_wack = 1'b0; s_rack = 1'b0; s_rdata = '0;

    do_reset();
    chk("rst_grant", grant, 32'h0);
    chk("rst_sreq", {s_wreq, s_rreq}, 32'h0);
    chk("rst_timeout", timeout, 32'h0);

    // single m0 write, slave acks in its second request cycle
    clear_stats();
    c0 = cyc;
    lat_q.push_back(2);
    wreq[0] = 1'b1; waddr[0] = WA'(3); wdata[0] = 32'hA5;
    run_until(1, 20, "t1");
    chk("t1_sreq_start", first_sreq_cyc, c0 + 1);
    chk("t1_sreq_len", sreq_cnt, 2);
    chk("t1_waddr", first_addr, 32'h3);
    chk("t1_wdata", first_wdata, 32'hA5);
    chk("t1_src", q_at(0), 0);
    chk("t1_ack_cyc", (ack_cyc.size() > 0) ? ack_cyc[0] : -1, c0 + 3);

    // simultaneous reads from both masters after reset
    do_reset();
    clear_stats();
    lat_q.push_back(1); lat_q.push_back(1);
    rd_q.push_back(32'h11); rd_q.push_back(32'h22);
    rreq[0] = 1'b1; raddr[0] = WA'(5);
    rreq[1] = 1'b1; raddr[1] = WA'(6);
    run_until(2, 30, "t2");
    chk("t2_first", q_at(0), 1);
    chk("t2_second", q_at(1), 3);
    chk("t2_m0_rdata", rd_seen[0], 32'h11);
    chk("t2_m1_rdata", rd_seen[1], 32'h22);
    chk("t2_grant0", (grant_q.size() > 0) ? grant_q[0] : -1, 0);
    chk("t2_grant1", (grant_q.size() > 1) ? grant_q[1] : -1, 1);

    // m1 reading continuously against three m0 writes
    do_reset();
    clear_stats();
    w_left[0] = 3; r_auto[1] = 1'b1;
    run_until(6, 120, "t3");
    r_auto[1] = 1'b0;
    for (int j = 0; j < 6; j++) chk($sformatf("t3_order%0d", j), q_at(j), (j % 2 == 1) ? 3 : 0);

    // m1 read that the slave never acks, then a late ack
    do_reset();
    clear_stats();
    lat_q.push_back(20);
    rreq[1] = 1'b1; raddr[1] = WA'(7);
    run_until(1, 30, "t4");
    chk("t4_sreq_len", sreq_cnt, TO);
    chk("t4_to_pulses", to_cnt, 1);
    chk("t4_src", q_at(0), 3);
    chk("t4_rdata", rd_seen[1], ERR);
    late_ack = 1'b1;
    repeat (6) cycle();
    chk("t4_late_acks", ack_q.size(), 1);
    chk("t4_late_to", to_cnt, 1);

    // m0 write and read pending together
    do_reset();
    clear_stats();
    lat_q.push_back(1); lat_q.push_back(1);
    wreq[0] = 1'b1; waddr[0] = WA'(9); wdata[0] = 32'h5A5A;
    rreq[0] = 1'b1; raddr[0] = WA'(10);
    run_until(2, 30, "t5");
    chk("t5_first", q_at(0), 0);
    chk("t5_second", q_at(1), 1);

    // reset in the middle of a transaction
    do_reset();
    clear_stats();
    lat_q.push_back(20);
    wreq[0] = 1'b1; waddr[0] = WA'(12); wdata[0] = 32'h77;
    cycle();
    cycle();
    rst = 1'b1;
    clear_reqs();
    cycle();
    rst = 1'b0;
    chk("t6_sreq", {s_wreq, s_rreq}, 32'h0);
    chk("t6_acks", {wack[0], rack[0], wack[1], rack[1]}, 32'h0);
    cycle();
    chk("t6_no_ack", ack_q.size(), 0);
    lat_q.push_back(1);
    rreq[0] = 1'b1; raddr[0] = WA'(13);
    run_until(1, 20, "t6");
    chk("t6_post", q_at(0), 1);

    // randomized traffic with stray slave acks and occasional resets
    do_reset();
    clear_stats();
    rand_mode = 1'b1; spur_en = 1'b1;
    repeat (3000) begin
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        clear_reqs();
      end
      cycle();
      rst = 1'b0;
    end
    rand_mode = 1'b0; spur_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
